// File: rtl/led_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// led_ctrl_pkg
//   Shared definitions for the board LED control path: debounce state
//   encodings, display-mode constants, default timing limits and the
//   mode-stepping helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package led_ctrl_pkg;

  localparam int CNT_W = 25;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [1:0]       mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS_W = 2'd1,
    PRESSED = 2'd2,
    REL_W   = 2'd3
  } deb_state_t;

  localparam mode_t MODE_BLINK    = 2'd0;
  localparam mode_t MODE_RUN      = 2'd1;
  localparam mode_t MODE_PINGPONG = 2'd2;
  localparam mode_t MODE_ALLON    = 2'd3;

  // Last count values: DEB_MAX+1 cycles = 20 ms, TICK_MAX+1 cycles = 0.5 s at 50 MHz.
  localparam cnt_t DEB_MAX_DEF  = 25'd999_999;
  localparam cnt_t TICK_MAX_DEF = 25'd24_999_999;

  // Step to the next display mode, wrapping after the last legal one.
  function automatic mode_t next_mode(input mode_t m, input int n_modes);
    return (m == mode_t'(n_modes - 1)) ? MODE_BLINK : mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Synchronises the raw active-low push button and debounces it with a
//   four-state FSM. A level change is accepted only after the synchronised
//   input has held the new level for a full DEB_MAX+1 cycle window.
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   key_n      in   raw button, active-low, asynchronous, bouncy
//   key_level  out  debounced level, 1 = pressed (registered)
//   key_press  out  one-cycle pulse per accepted press (registered)
// -----------------------------------------------------------------------------
module key_debounce
  import led_ctrl_pkg::*;
#(
  parameter cnt_t DEB_MAX = DEB_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic key_press
);

  logic       sync_p0;
  logic       sync_p1;   // key_s: synchronised button, 0 = pressed
  deb_state_t state;
  deb_state_t state_nxt;
  cnt_t       deb_cnt;
  cnt_t       deb_cnt_nxt;
  logic       press_nxt;
  logic       level_nxt;

  // ---- stage p0/p1: two-flop synchroniser, resets to "released" ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

  // ---- FSM state register (outputs registered alongside state) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      key_level <= 1'b0;
      key_press <= 1'b0;
    end else begin
      state     <= state_nxt;
      deb_cnt   <= deb_cnt_nxt;
      key_level <= level_nxt;
      key_press <= press_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    deb_cnt_nxt = deb_cnt;
    case (state)
      IDLE: begin
        if (!sync_p1) begin
          state_nxt   = PRESS_W;
          deb_cnt_nxt = '0;
        end
      end
      PRESS_W: begin
        if (sync_p1) begin
          state_nxt = IDLE;
        end else if (deb_cnt == DEB_MAX) begin
          state_nxt = PRESSED;
        end else begin
          deb_cnt_nxt = deb_cnt + 25'd1;
        end
      end
      PRESSED: begin
        if (sync_p1) begin
          state_nxt   = REL_W;
          deb_cnt_nxt = '0;
        end
      end
      REL_W: begin
        // Falling back to PRESSED is a glitch during release, not a new press.
        if (!sync_p1) begin
          state_nxt = PRESSED;
        end else if (deb_cnt == DEB_MAX) begin
          state_nxt = IDLE;
        end else begin
          deb_cnt_nxt = deb_cnt + 25'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    press_nxt = 1'b0;
    level_nxt = 1'b0;
    if ((state == PRESS_W) && !sync_p1 && (deb_cnt == DEB_MAX)) begin
      press_nxt = 1'b1;
    end
    if ((state_nxt == PRESSED) || (state_nxt == REL_W)) begin
      level_nxt = 1'b1;
    end
  end

endmodule

// File: rtl/key_mode_ctrl.sv
// -----------------------------------------------------------------------------
// key_mode_ctrl
//   Upstream control stage for the LED driver: debounced button, display
//   mode register stepped on each clean press, and the periodic blink tick.
//   A mode change restarts the tick period so every new mode begins with a
//   full period.
// Ports
//   clk        in   50 MHz system clock, rising edge
//   rst        in   synchronous active-high reset
//   key_n      in   raw push button, active-low, asynchronous
//   key_level  out  debounced button level, 1 = pressed
//   key_press  out  one-cycle pulse per debounced press
//   mode       out  current display mode, 0..N_MODES-1
//   tick       out  one-cycle strobe every TICK_MAX+1 cycles
// -----------------------------------------------------------------------------
module key_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter cnt_t DEB_MAX  = DEB_MAX_DEF,
  parameter cnt_t TICK_MAX = TICK_MAX_DEF,
  parameter int   N_MODES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  output logic       key_level,
  output logic       key_press,
  output logic [1:0] mode,
  output logic       tick
);

  if ((DEB_MAX < 25'd1) || (TICK_MAX < 25'd1) || (N_MODES < 2) || (N_MODES > 4)) begin : g_param_chk
    $error("key_mode_ctrl: DEB_MAX/TICK_MAX must be >= 1 and N_MODES in 2..4");
  end

  cnt_t tick_cnt;

  key_debounce #(
    .DEB_MAX (DEB_MAX)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .key_level (key_level),
    .key_press (key_press)
  );

  // ---- mode register and tick divider; a press outranks a tick wrap ----
  always_ff @(posedge clk) begin
    if (rst) begin
      mode     <= MODE_BLINK;
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (key_press) begin
      mode     <= next_mode(mode, N_MODES);
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (tick_cnt == TICK_MAX) begin
      tick_cnt <= '0;
      tick     <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 25'd1;
      tick     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_mode_ctrl
//   Directed bench for key_mode_ctrl with DEB_MAX=9, TICK_MAX=24, N_MODES=4.
//   A behavioural model tracks the expected outputs every cycle; literal
//   edge-numbered expectations pin the model's timing.
// -----------------------------------------------------------------------------
module tb_key_mode_ctrl;

  localparam int DEB  = 9;
  localparam int TMAX = 24;
  localparam int NM   = 4;
  localparam int RUN_NEED = DEB + 2;  // consecutive synchronised samples to accept a change

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_n = 1'b1;
  logic       key_level;
  logic       key_press;
  logic [1:0] mode;
  logic       tick;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int presses = 0;

  key_mode_ctrl #(
    .DEB_MAX  (25'd9),
    .TICK_MAX (25'd24),
    .N_MODES  (NM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .key_level (key_level),
    .key_press (key_press),
    .mode      (mode),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  // Behavioural model: key_n reaches the debouncer two edges late; the
  // debounced level flips once the raw level has disagreed with it for
  // RUN_NEED consecutive samples.
  int m_d1 = 1, m_d2 = 1, m_run = 0, m_tcnt = 0, m_mode = 0;
  int m_level = 0, m_press = 0, m_tick = 0;
  int ks;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_d1 = 1; m_d2 = 1; m_run = 0; m_tcnt = 0; m_mode = 0;
      m_level = 0; m_press = 0; m_tick = 0;
    end else begin
      ks = m_d2;
      m_d2 = m_d1;
      m_d1 = int'(key_n);
      if (m_press != 0) begin
        m_mode = (m_mode + 1) % NM;
        m_tcnt = 0;
        m_tick = 0;
      end else if (m_tcnt == TMAX) begin
        m_tcnt = 0;
        m_tick = 1;
      end else begin
        m_tcnt = m_tcnt + 1;
        m_tick = 0;
      end
      m_press = 0;
      if (((ks == 0) ? 1 : 0) != m_level) m_run = m_run + 1;
      else m_run = 0;
      if (m_run == RUN_NEED) begin
        m_level = 1 - m_level;
        m_run = 0;
        m_press = m_level;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_key_level", 32'(key_level), 32'(m_level));
    chk("model_key_press", 32'(key_press), 32'(m_press));
    chk("model_mode", 32'(mode), 32'(m_mode));
    chk("model_tick", 32'(tick), 32'(m_tick));
    if (key_press === 1'b1) presses++;
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int rel, e0, pc0, mode0;
  int exp_modes[4] = '{1, 2, 3, 0};

  initial begin
    // 1: reset for 5 edges, then tick cadence
    rst = 1'b1;
    key_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_level", 32'(key_level), 0);
    chk("rst_press", 32'(key_press), 0);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_tick", 32'(tick), 0);
    rst = 1'b0;
    rel = cyc;
    wait_until(rel + 24); chk("tick_pre_first", 32'(tick), 0);
    wait_until(rel + 25); chk("tick_first", 32'(tick), 1);
    wait_until(rel + 26); chk("tick_after_first", 32'(tick), 0);
    wait_until(rel + 50); chk("tick_second", 32'(tick), 1);

    // 2: clean press held 40 cycles
    e0 = cyc + 1;
    key_n = 1'b0;
    wait_until(e0 + 11);
    chk("press_early", 32'(key_press), 0);
    chk("level_early", 32'(key_level), 0);
    wait_until(e0 + 12);
    chk("press_on_time", 32'(key_press), 1);
    chk("level_on_time", 32'(key_level), 1);
    chk("mode_before_step", 32'(mode), 0);
    wait_until(e0 + 13);
    chk("press_one_cycle", 32'(key_press), 0);
    chk("mode_stepped", 32'(mode), 1);
    chk("tick_cleared", 32'(tick), 0);
    wait_until(e0 + 37); chk("tick_restart_pre", 32'(tick), 0);
    wait_until(e0 + 38); chk("tick_restart", 32'(tick), 1);
    wait_until(e0 + 39);
    key_n = 1'b1;
    wait_until(e0 + 51); chk("release_pending", 32'(key_level), 1);
    wait_until(e0 + 52); chk("release_done", 32'(key_level), 0);
    repeat (5) @(negedge clk);

    // 3: bounce never holds long enough
    pc0 = presses;
    mode0 = int'(mode);
    key_n = 1'b0; repeat (6) @(negedge clk);
    key_n = 1'b1; repeat (2) @(negedge clk);
    key_n = 1'b0; repeat (5) @(negedge clk);
    key_n = 1'b1; repeat (20) @(negedge clk);
    chk("bounce_presses", 32'(presses), 32'(pc0));
    chk("bounce_mode", 32'(mode), 32'(mode0));
    chk("bounce_level", 32'(key_level), 0);

    // 4: four clean presses from mode 0
    rst = 1'b1; repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst2_mode", 32'(mode), 0);
    pc0 = presses;
    for (int k = 0; k < 4; k++) begin
      key_n = 1'b0; repeat (14) @(negedge clk);
      key_n = 1'b1; repeat (14) @(negedge clk);
      chk("seq_mode", 32'(mode), 32'(exp_modes[k]));
    end
    chk("seq_presses", 32'(presses), 32'(pc0 + 4));

    // 5: glitch high for 4 cycles while held
    pc0 = presses;
    key_n = 1'b0; repeat (20) @(negedge clk);
    key_n = 1'b1; repeat (4) @(negedge clk);
    key_n = 1'b0; repeat (8) @(negedge clk);
    chk("glitch_level", 32'(key_level), 1);
    repeat (12) @(negedge clk);
    key_n = 1'b1; repeat (20) @(negedge clk);
    chk("glitch_presses", 32'(presses), 32'(pc0 + 1));
    chk("glitch_mode", 32'(mode), 1);

    // 6: reset mid-debounce with the key still held
    e0 = cyc + 1;
    key_n = 1'b0;
    wait_until(e0 + 7);
    rst = 1'b1;
    wait_until(e0 + 8);
    rst = 1'b0;
    chk("midrst_mode", 32'(mode), 0);
    wait_until(e0 + 12);
    chk("midrst_no_orig_press", 32'(key_press), 0);
    wait_until(e0 + 20);
    chk("midrst_press_early", 32'(key_press), 0);
    wait_until(e0 + 21);
    chk("midrst_press", 32'(key_press), 1);
    chk("midrst_mode_hold", 32'(mode), 0);
    wait_until(e0 + 22);
    chk("midrst_mode_step", 32'(mode), 1);
    key_n = 1'b1;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
